// File: rtl/apb_uart_arb.sv
// Two-port APB master with round-robin arbitration in front of the UART APB slave.
// The slave has no pready, so reads wait a fixed RD_LAT cycles before capturing prdata.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | sample requests, pick winner, latch winner's wr/addr/wdata
// S_SETUP  | APB setup phase: psel=1, penable=0
// S_ACCESS | APB access phase: psel=1, penable=1
// S_RWAIT  | read latency countdown, capture prdata at terminal count
// S_DONE   | one-cycle ack to the winning port
module apb_uart_arb #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RWAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_t              state_q;
  logic                sel_q;
  logic                rr_last_q;
  logic [3:0]          cnt_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                busy_q;
  logic                grant1_d;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    grant1_d = 1'b0;
    grant1_d = req1 & (~req0 | ~rr_last_q);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            sel_q    <= grant1_d;
            if (req0 && req1) rr_last_q <= grant1_d;
            pwrite_q <= grant1_d ? wr1    : wr0;
            paddr_q  <= grant1_d ? addr1  : addr0;
            pwdata_q <= grant1_d ? wdata1 : wdata0;
            psel_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (pwrite_q || (RD_LAT == 0)) begin
            if (!pwrite_q) begin
              if (sel_q) rdata1_q <= prdata;
              else       rdata0_q <= prdata;
            end
            ack0_q  <= ~sel_q;
            ack1_q  <= sel_q;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (cnt_q == 4'd0) begin
            if (sel_q) rdata1_q <= prdata;
            else       rdata0_q <= prdata;
            ack0_q  <= ~sel_q;
            ack1_q  <= sel_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_apb_uart_arb.sv
// Directed bench for apb_uart_arb: one instance with RD_LAT=2, one with RD_LAT=0.
`timescale 1ns/1ps
module tb_apb_uart_arb;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req0, wr0, req1, wr1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, pwdata, prdata;
  logic        ack0, ack1, psel, penable, pwrite, busy;
  logic [5:0]  paddr;

  logic        b_req0, b_wr0, b_req1, b_wr1;
  logic [5:0]  b_addr0, b_addr1;
  logic [31:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_pwdata, b_prdata;
  logic        b_ack0, b_ack1, b_psel, b_penable, b_pwrite, b_busy;
  logic [5:0]  b_paddr;

  int n_checks = 0;
  int n_err    = 0;

  logic        ob_psel [8];
  logic        ob_pen  [8];
  logic        ob_busy [8];
  logic [5:0]  ob_paddr;
  logic        ob_pwrite;
  logic [31:0] ob_pwdata;

  always #5 pclk = ~pclk;

  apb_uart_arb #(.ADDR_W(6), .DATA_W(32), .RD_LAT(2)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .busy(busy)
  );

  apb_uart_arb #(.ADDR_W(6), .DATA_W(32), .RD_LAT(0)) dut_lat0 (
    .pclk(pclk), .presetn(presetn),
    .req0(b_req0), .wr0(b_wr0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .wr1(b_wr1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .paddr(b_paddr), .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .pwdata(b_pwdata),
    .prdata(b_prdata), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drop_req(input int port);
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
  endtask

  // Starts a request in an IDLE cycle; k counts negedges from that IDLE cycle.
  task automatic xfer(input int port, input logic wr, input logic [5:0] addr,
                      input logic [31:0] wd, input bit drop_access,
                      output int lat, output int n_own, output int n_other);
    logic own, other;
    lat = -1; n_own = 0; n_other = 0;
    @(posedge pclk); #1;
    if (port == 0) begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wd; end
    else           begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wd; end
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (k < 8) begin ob_psel[k] = psel; ob_pen[k] = penable; ob_busy[k] = busy; end
      if (k == 2) begin
        ob_paddr = paddr; ob_pwrite = pwrite; ob_pwdata = pwdata;
        if (drop_access) drop_req(port);
      end
      own   = (port == 0) ? ack0 : ack1;
      other = (port == 0) ? ack1 : ack0;
      if (own) begin
        n_own++;
        if (lat < 0) lat = k;
        drop_req(port);
      end
      if (other) n_other++;
      if (lat >= 0 && k >= lat + 3) break;
    end
    drop_req(port);
  endtask

  int lat, n_own, n_other;
  int order [4];
  int n_acks, n_both, first_port;

  initial begin
    presetn = 1'b0;
    req0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    prdata = '0;
    b_req0 = 0; b_wr0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_wr1 = 0; b_addr1 = '0; b_wdata1 = '0;
    b_prdata = '0;
    repeat (2) @(negedge pclk);
    check("rst_psel",   32'(psel),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_paddr",  32'(paddr),  32'd0);
    check("rst_rdata0", rdata0,      32'd0);
    presetn = 1'b1;

    // port 0 write
    xfer(0, 1'b1, 6'h8, 32'h41, 1'b0, lat, n_own, n_other);
    check("wr_lat",     lat,             32'd3);
    check("wr_nack0",   n_own,           32'd1);
    check("wr_ack1",    n_other,         32'd0);
    check("wr_idle_ps", 32'(ob_psel[0]), 32'd0);
    check("wr_setup_ps",32'(ob_psel[1]), 32'd1);
    check("wr_setup_pe",32'(ob_pen[1]),  32'd0);
    check("wr_setup_bz",32'(ob_busy[1]), 32'd1);
    check("wr_acc_ps",  32'(ob_psel[2]), 32'd1);
    check("wr_acc_pe",  32'(ob_pen[2]),  32'd1);
    check("wr_paddr",   32'(ob_paddr),   32'h8);
    check("wr_pwrite",  32'(ob_pwrite),  32'd1);
    check("wr_pwdata",  ob_pwdata,       32'h41);

    // RD_LAT=0 instance: capture at ACCESS edge, then prdata changes in DONE
    b_prdata = 32'h77;
    lat = -1;
    @(posedge pclk); #1;
    b_req0 = 1'b1; b_wr0 = 1'b0; b_addr0 = 6'h10;
    n_other = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (k == 1) check("l0_setup_ps", 32'(b_psel), 32'd1);
      if (k == 2) begin
        check("l0_acc_pe",  32'(b_penable), 32'd1);
        check("l0_paddr",   32'(b_paddr),   32'h10);
        check("l0_pwdata",  b_pwdata,       32'd0);
      end
      if (b_ack0 && lat < 0) begin lat = k; b_req0 = 1'b0; end
      if (b_ack1) n_other++;
      if (k == 3) b_prdata = 32'h99;
      if (lat >= 0 && k >= lat + 2) break;
    end
    b_req0 = 1'b0;
    check("l0_lat",    lat,      32'd3);
    check("l0_rdata0", b_rdata0, 32'h77);
    check("l0_ack1",   n_other,  32'd0);
    check("l0_rdata1", b_rdata1, 32'd0);
    check("l0_busy",   32'(b_busy), 32'd0);

    // port 1 read, RD_LAT=2
    prdata = 32'h5A;
    xfer(1, 1'b0, 6'h8, 32'h0, 1'b0, lat, n_own, n_other);
    check("rd_lat",      lat,             32'd5);
    check("rd_nack1",    n_own,           32'd1);
    check("rd_ack0",     n_other,         32'd0);
    check("rd_rdata1",   rdata1,          32'h5A);
    check("rd_pwrite",   32'(ob_pwrite),  32'd0);
    check("rd_rwait_ps", 32'(ob_psel[3]), 32'd0);
    check("rd_rwait_bz", 32'(ob_busy[3]), 32'd1);

    // both ports held high for four transfers
    @(posedge pclk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 6'h1; wdata0 = 32'hA0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 6'h2; wdata1 = 32'hB1;
    n_acks = 0; n_both = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (ack0 && ack1) n_both++;
      if ((ack0 || ack1) && n_acks < 4) begin
        order[n_acks] = ack1 ? 1 : 0;
        n_acks++;
      end
      if (n_acks == 4) begin req0 = 1'b0; req1 = 1'b0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_nacks", n_acks, 32'd4);
    check("rr_both",  n_both, 32'd0);
    check("rr_g0",    order[0], 32'd0);
    check("rr_g1",    order[1], 32'd1);
    check("rr_g2",    order[2], 32'd0);
    check("rr_g3",    order[3], 32'd1);
    repeat (2) @(negedge pclk);
    check("rr_idle_busy", 32'(busy), 32'd0);

    // req0 dropped during ACCESS
    xfer(0, 1'b1, 6'h4, 32'h3, 1'b1, lat, n_own, n_other);
    check("drop_lat",   lat,           32'd3);
    check("drop_nack0", n_own,         32'd1);
    check("drop_ack1",  n_other,       32'd0);
    check("drop_paddr", 32'(ob_paddr), 32'h4);
    check("drop_pwdata",ob_pwdata,     32'h3);

    // reset during the read wait
    @(posedge pclk); #1;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 6'h8;
    repeat (4) @(negedge pclk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    presetn = 1'b0;
    #1;
    req1 = 1'b0;
    check("mrst_psel",   32'(psel),    32'd0);
    check("mrst_pen",    32'(penable), 32'd0);
    check("mrst_ack0",   32'(ack0),    32'd0);
    check("mrst_ack1",   32'(ack1),    32'd0);
    check("mrst_busy",   32'(busy),    32'd0);
    check("mrst_rdata1", rdata1,       32'd0);
    @(negedge pclk);
    check("mrst_ack1_n", 32'(ack1), 32'd0);
    presetn = 1'b1;

    @(posedge pclk); #1;
    req0 = 1'b1; req1 = 1'b1;
    first_port = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (ack0 || ack1) begin first_port = ack1 ? 1 : 0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("post_rst_tie", first_port, 32'd0);
    repeat (3) @(negedge pclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
